alu_mb_seq: RTL and testbench

Multi-byte arithmetic sequencer that drives one `alu_8bit` instance serially, one byte per cycle, to perform NBYTES-wide add, increment, negate and subtract operations. It chains the carry between bytes in a register. It latches operands on a start handshake and returns a registered result with carry, zero and signed-overflow flags. It sits between the control unit and the 8-bit ALU datapath.

---
 rtl/alu_mb_pkg.sv | 23 ++
 rtl/alu_8bit.sv | 30 +++
 rtl/alu_mb_seq.sv | 114 +++++++++++
 tb/tb_alu_mb_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mb_pkg.sv
// Shared types for the multi-byte ALU sequencer: operation codes, FSM states
// and the per-operation carry-in seed.
package alu_mb_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_INC = 2'b01,
    OP_NEG = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // INC, NEG and SUB all need the +1 of a two's-complement step in byte 0.
  function automatic logic init_carry(op_e op);
    return (op != OP_ADD);
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// 8-bit add-based ALU slice: ADD a+b+c, INC a+c, NEG ~b+c, SUB a+~b+c.
module alu_8bit
  import alu_mb_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       s1,
  input  logic       s0,
  input  logic       cin,
  output logic [7:0] f,
  output logic       cout
);

  logic [7:0] x;
  logic [7:0] y;

  always_comb begin
    x = a;
    y = b;
    unique case (op_e'({s1, s0}))
      OP_ADD: begin x = a;  y = b;    end
      OP_INC: begin x = a;  y = '0;   end
      OP_NEG: begin x = ~b; y = '0;   end
      OP_SUB: begin x = a;  y = ~b;   end
    endcase
  end

  assign {cout, f} = {1'b0, x} + {1'b0, y} + {8'b0, cin};

endmodule

// File: rtl/alu_mb_seq.sv
// Multi-byte arithmetic sequencer: runs one alu_8bit serially over NBYTES
// bytes with a registered carry chain and registered result/flags.
module alu_mb_seq
  import alu_mb_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                zero,
  output logic                ovf
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = $clog2(NBYTES);

  state_e          state, state_nx;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    acc, acc_nx;
  logic [W-1:0]    a_q, b_q;
  op_e             op_q;
  logic            accept, last, ovf_nx;
  logic [IW+2:0]   base;
  logic [7:0]      alu_f;
  logic            alu_cout;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (idx == IW'(NBYTES - 1));
  assign base   = {idx, 3'b000};
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  alu_8bit u_alu (
    .a    (a_q[base +: 8]),
    .b    (b_q[base +: 8]),
    .s1   (op_q[1]),
    .s0   (op_q[0]),
    .cin  (carry),
    .f    (alu_f),
    .cout (alu_cout)
  );

  // The final byte is merged combinationally so the flags see the full word.
  always_comb begin
    acc_nx = acc;
    acc_nx[base +: 8] = alu_f;
  end

  always_comb begin
    ovf_nx = 1'b0;
    unique case (op_q)
      OP_ADD: ovf_nx = (a_q[W-1] == b_q[W-1]) && (acc_nx[W-1] != a_q[W-1]);
      OP_SUB: ovf_nx = (a_q[W-1] != b_q[W-1]) && (acc_nx[W-1] != a_q[W-1]);
      OP_INC: ovf_nx = !a_q[W-1] && acc_nx[W-1];
      OP_NEG: ovf_nx = (b_q == {1'b1, {(W-1){1'b0}}});
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      op_q  <= op_e'(op);
      idx   <= '0;
      carry <= init_carry(op_e'(op));
    end else if (state == RUN) begin
      acc   <= acc_nx;
      carry <= alu_cout;
      idx   <= idx + 1'b1;
      if (last) begin
        result <= acc_nx;
        cout   <= alu_cout;
        zero   <= (acc_nx == '0);
        ovf    <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_alu_mb_seq.sv
// Self-checking bench for alu_mb_seq (NBYTES=4): scoreboard of word-level
// expected results plus per-scenario timing and constant checks.
module tb_alu_mb_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, cout, zero, ovf;
  logic [W-1:0] result;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  alu_mb_seq #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .zero   (zero),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
    exp_t e;
    logic [W:0] s;
    logic sa, sb, sr;
    case (o)
      2'b00:   s = {1'b0, x} + {1'b0, y};
      2'b01:   s = {1'b0, x} + 1;
      2'b10:   s = {1'b0, ~y} + 1;
      default: s = {1'b0, x} + {1'b0, ~y} + 1;
    endcase
    sa = x[W-1]; sb = y[W-1]; sr = s[W-1];
    e.res = s[W-1:0];
    e.c   = s[W];
    e.z   = (s[W-1:0] == '0);
    case (o)
      2'b00:   e.v = (sa == sb) && (sr != sa);
      2'b01:   e.v = !sa && sr;
      2'b10:   e.v = (y == {1'b1, {(W-1){1'b0}}});
      default: e.v = (sa != sb) && (sr != sa);
    endcase
    return e;
  endfunction

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, required not both 1", busy, done);
      end
      if (done) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_done: done=1 with no pending operation, required done=0");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (result !== e.res || cout !== e.c || zero !== e.z || ovf !== e.v) begin
            errors++;
            $display("FAIL sb_result: got res=%h c=%b z=%b v=%b, required res=%h c=%b z=%b v=%b",
                     result, cout, zero, ovf, e.res, e.c, e.z, e.v);
          end
        end
      end
    end
  end

  // Drives a start for one edge; push=0 leaves the scoreboard untouched.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit push);
    start = 1'b1; op = o; a = x; b = y;
    if (push) sb_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, n);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string name);
    start_op(o, x, y, 1'b1);
    wait_done(name);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, cout, zero, ovf} !== 5'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b res=%h c=%b z=%b v=%b, required all 0",
               busy, done, result, cout, zero, ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_timing;
    int edges = 0, busy_cnt = 0;
    start = 1'b1; op = 2'b00; a = 32'h0000_00FF; b = 32'h0000_0001;
    sb_q.push_back(model(2'b00, a, b));
    while (edges < 20) begin
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    checks++;
    if (edges != NB + 1) begin
      errors++;
      $display("FAIL add_latency: done after %0d edges, required %0d", edges, NB + 1);
    end
    checks++;
    if (busy_cnt != NB) begin
      errors++;
      $display("FAIL add_busy_len: busy %0d cycles, required %0d", busy_cnt, NB);
    end
    checks++;
    if (result !== 32'h0000_0100 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_value: res=%h c=%b z=%b v=%b, required 00000100 0 0 0",
               result, cout, zero, ovf);
    end
  endtask

  task automatic test_sub;
    run_op(2'b11, 32'h5, 32'h5, "sub_eq");
    checks++;
    if (result !== '0 || cout !== 1'b1 || zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_eq: res=%h c=%b z=%b v=%b, required 00000000 1 1 0", result, cout, zero, ovf);
    end
    run_op(2'b11, 32'h8000_0000, 32'h1, "sub_ovf");
    checks++;
    if (result !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf: res=%h v=%b, required 7fffffff 1", result, ovf);
    end
  endtask

  task automatic test_inc;
    run_op(2'b01, 32'hFFFF_FFFF, 32'h1234_5678, "inc_wrap");
    checks++;
    if (result !== '0 || cout !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap: res=%h c=%b z=%b, required 00000000 1 1", result, cout, zero);
    end
    run_op(2'b01, 32'h7FFF_FFFF, 32'h0, "inc_ovf");
    checks++;
    if (result !== 32'h8000_0000 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL inc_ovf: res=%h v=%b, required 80000000 1", result, ovf);
    end
  endtask

  task automatic test_neg;
    run_op(2'b10, 32'hDEAD_BEEF, 32'h1, "neg_one");
    checks++;
    if (result !== 32'hFFFF_FFFF || cout !== 1'b0) begin
      errors++;
      $display("FAIL neg_one: res=%h c=%b, required ffffffff 0", result, cout);
    end
    run_op(2'b10, 32'h0, 32'h0, "neg_zero");
    checks++;
    if (result !== '0 || cout !== 1'b1 || zero !== 1'b1) begin
      errors++;
      $display("FAIL neg_zero: res=%h c=%b z=%b, required 00000000 1 1", result, cout, zero);
    end
    run_op(2'b10, 32'h0, 32'h8000_0000, "neg_min");
    checks++;
    if (ovf !== 1'b1 || result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL neg_min: res=%h v=%b, required 80000000 1", result, ovf);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] o = 2'($urandom_range(0, 3));
      run_op(o, W'($urandom), W'($urandom), "rand");
    end
  endtask

  task automatic test_start_held;
    start = 1'b1; op = 2'b00; a = 32'h1; b = 32'h2;
    sb_q.push_back(model(2'b00, a, b));
    for (int i = 0; i < NB; i++) begin
      @(posedge clk); #1;
      op = 2'($urandom_range(1, 3)); a = W'($urandom); b = W'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'h3) begin
      errors++;
      $display("FAIL start_held: done=%b res=%h, required 1 00000003", done, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    run_op(2'b00, 32'h1111_1111, 32'h2222_2222, "b2b_first");
    start_op(2'b11, 32'h10, 32'h20, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart: busy=%b done=%b, required 1 0", busy, done);
    end
    wait_done("b2b_second");
    checks++;
    if (result !== 32'hFFFF_FFF0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: res=%h c=%b, required fffffff0 0", result, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int dones = 0;
    start_op(2'b00, 32'h0101_0101, 32'h0202_0202, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b res=%h, required 0 00000000", busy, result);
    end
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL aborted_done: %0d done pulses, required 0", dones);
    end
    run_op(2'b00, 32'h0000_00FF, 32'h0000_0001, "post_reset_add");
    checks++;
    if (result !== 32'h0000_0100) begin
      errors++;
      $display("FAIL post_reset_add: res=%h, required 00000100", result);
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_sub();
    test_inc();
    test_neg();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d pending results, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
